// File: rtl/stack_unit.sv
// Stack engine: PUSH/POP/CALL/RET against a full-descending stack in external memory.
// Latency: 3 cycles accept-to-ready with a same-cycle mem_ack, plus one per ack wait cycle.
// Backpressure: cmd_ready is low from accept until the command's UPD cycle has completed.
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      : command handshake; cmd_op 0 PUSH, 1 POP, 2 CALL, 3 RET
//   cmd_data, cmd_rd         : PUSH data / CALL target, POP destination register
//   sp_cur, pc_cur           : current SP/PC from the register file
//   sp_wr/sp_in, pc_wr/pc_in : SP/PC write-back strobes and data
//   wr_en/rd_addr/rd_data    : GPR write-back for POP
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack : single-beat memory port
//   done, err                : one-cycle completion pulse, guarded-fault pulse
//
// Optional feature: define STACK_GUARD_EN to bound-check SP against SP_BOTTOM/SP_TOP.
// Without it err is constant 0 and SP wraps modulo 2^16.
module stack_unit #(
    parameter logic [15:0] SP_TOP    = 16'hFFFF,
    parameter logic [15:0] SP_BOTTOM = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_data,
    input  logic [3:0]  cmd_rd,
    input  logic [15:0] sp_cur,
    input  logic [15:0] pc_cur,
    output logic        sp_wr,
    output logic        pc_wr,
    output logic        wr_en,
    output logic [15:0] sp_in,
    output logic [15:0] pc_in,
    output logic [15:0] rd_data,
    output logic [3:0]  rd_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        done,
    output logic        err
);

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_POP  = 2'd1;
    localparam logic [1:0] OP_CALL = 2'd2;
    localparam logic [1:0] OP_RET  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_UPD  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_nxt;

    // Command fields captured at accept.
    logic [1:0]  op_q;
    logic [15:0] data_q;
    logic [3:0]  rd_q;
    logic [15:0] sp_q;
    logic [15:0] pc_q;

    logic accept;
    assign accept = cmd_valid && cmd_ready;

    // Every output is a flop, so its next value is computed from the next
    // state. On the accept edge the capture registers are not loaded yet,
    // so the "effective" command comes straight from the inputs in IDLE.
    logic        in_idle;
    logic [1:0]  eff_op;
    logic [15:0] eff_data;
    logic [3:0]  eff_rd;
    logic [15:0] eff_sp;
    logic [15:0] eff_pc;
    logic        eff_dec;   // PUSH/CALL: pre-decrement write

    assign in_idle  = (state_q == S_IDLE);
    assign eff_op   = in_idle ? cmd_op   : op_q;
    assign eff_data = in_idle ? cmd_data : data_q;
    assign eff_rd   = in_idle ? cmd_rd   : rd_q;
    assign eff_sp   = in_idle ? sp_cur   : sp_q;
    assign eff_pc   = in_idle ? pc_cur   : pc_q;
    assign eff_dec  = (eff_op == OP_PUSH) || (eff_op == OP_CALL);

    // Bound check. fault_eff is only meaningful on the accept edge and
    // while the faulted command sits in UPD.
    logic fault_eff;
`ifdef STACK_GUARD_EN
    logic fault_now;
    logic fault_q;

    assign fault_now = eff_dec ? (eff_sp == SP_BOTTOM) : (eff_sp == SP_TOP);
    assign fault_eff = in_idle ? fault_now : fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (accept) begin
            fault_q <= fault_now;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{SP_TOP, SP_BOTTOM};
    assign fault_eff  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // A faulted command never touches memory.
                    state_nxt = fault_eff ? S_UPD : S_MEM;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_nxt = S_UPD;
                end
            end
            S_UPD:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output next-values (registered below)
    // ------------------------------------------------------------------
    logic        cmd_ready_nxt;
    logic        mem_req_nxt;
    logic        mem_we_nxt;
    logic [15:0] mem_addr_nxt;
    logic [15:0] mem_wdata_nxt;
    logic        sp_wr_nxt;
    logic [15:0] sp_in_nxt;
    logic        pc_wr_nxt;
    logic [15:0] pc_in_nxt;
    logic        wr_en_nxt;
    logic [3:0]  rd_addr_nxt;
    logic [15:0] rd_data_nxt;
    logic        done_nxt;
    logic        err_nxt;

    always_comb begin
        cmd_ready_nxt = (state_nxt == S_IDLE);
        mem_req_nxt   = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = 16'h0000;
        mem_wdata_nxt = 16'h0000;
        sp_wr_nxt     = 1'b0;
        sp_in_nxt     = 16'h0000;
        pc_wr_nxt     = 1'b0;
        pc_in_nxt     = 16'h0000;
        wr_en_nxt     = 1'b0;
        rd_addr_nxt   = 4'h0;
        rd_data_nxt   = 16'h0000;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;

        if (state_nxt == S_MEM) begin
            // Recomputed every MEM cycle from the captured command, so the
            // request stays stable until mem_ack.
            mem_req_nxt  = 1'b1;
            mem_we_nxt   = eff_dec;
            mem_addr_nxt = eff_dec ? (eff_sp - 16'd1) : eff_sp;
            if (eff_op == OP_PUSH) begin
                mem_wdata_nxt = eff_data;
            end else if (eff_op == OP_CALL) begin
                mem_wdata_nxt = eff_pc + 16'd1;
            end
        end

        if (state_nxt == S_UPD) begin
            done_nxt = 1'b1;
            if (fault_eff) begin
                err_nxt = 1'b1;
            end else begin
                // Entering UPD from MEM happens on the ack cycle, so
                // mem_rdata is valid here and lands in the output flops.
                sp_wr_nxt = 1'b1;
                sp_in_nxt = eff_dec ? (eff_sp - 16'd1) : (eff_sp + 16'd1);
                case (eff_op)
                    OP_POP: begin
                        wr_en_nxt   = 1'b1;
                        rd_addr_nxt = eff_rd;
                        rd_data_nxt = mem_rdata;
                    end
                    OP_CALL: begin
                        pc_wr_nxt = 1'b1;
                        pc_in_nxt = eff_data;
                    end
                    OP_RET: begin
                        pc_wr_nxt = 1'b1;
                        pc_in_nxt = mem_rdata;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Command capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= 2'd0;
            data_q <= 16'h0000;
            rd_q   <= 4'h0;
            sp_q   <= 16'h0000;
            pc_q   <= 16'h0000;
        end else if (accept) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            rd_q   <= cmd_rd;
            sp_q   <= sp_cur;
            pc_q   <= pc_cur;
        end
    end

    // ------------------------------------------------------------------
    // Output registers. Reset clears them asynchronously, which drops
    // mem_req at once and kills any pending write-back.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_ready <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            sp_wr     <= 1'b0;
            sp_in     <= 16'h0000;
            pc_wr     <= 1'b0;
            pc_in     <= 16'h0000;
            wr_en     <= 1'b0;
            rd_addr   <= 4'h0;
            rd_data   <= 16'h0000;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            cmd_ready <= cmd_ready_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            sp_wr     <= sp_wr_nxt;
            sp_in     <= sp_in_nxt;
            pc_wr     <= pc_wr_nxt;
            pc_in     <= pc_in_nxt;
            wr_en     <= wr_en_nxt;
            rd_addr   <= rd_addr_nxt;
            rd_data   <= rd_data_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_stack_unit.sv
module tb_stack_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_data = 16'h0;
    logic [3:0]  cmd_rd = 4'h0;
    logic [15:0] sp_cur = 16'hFFFF;
    logic [15:0] pc_cur = 16'h0;
    logic        sp_wr, pc_wr, wr_en;
    logic [15:0] sp_in, pc_in, rd_data;
    logic [3:0]  rd_addr;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_ack = 1'b0;
    logic        done, err;

    stack_unit dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_rd(cmd_rd),
        .sp_cur(sp_cur), .pc_cur(pc_cur),
        .sp_wr(sp_wr), .pc_wr(pc_wr), .wr_en(wr_en),
        .sp_in(sp_in), .pc_in(pc_in), .rd_data(rd_data), .rd_addr(rd_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: architectural SP/PC plus the stack contents as a
    // queue (back = top of stack). phys is the bench's memory responder.
    logic [15:0] m_sp = 16'hFFFF;
    logic [15:0] m_pc = 16'h0100;
    logic [15:0] stk [$];
    logic [15:0] phys [65536];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one command at a negedge and follow it to completion.
    // waits = number of cycles mem_ack is held low in MEM.
    task automatic run_cmd(input logic [1:0] op, input logic [15:0] data,
                           input logic [3:0] rd, input int waits);
        logic        dec;
        logic [15:0] exp_addr, exp_wdata, exp_sp, exp_val;
        dec       = (op == 2'd0) || (op == 2'd2);
        exp_addr  = dec ? 16'(m_sp - 16'd1) : m_sp;
        exp_wdata = (op == 2'd0) ? data : 16'(m_pc + 16'd1);
        exp_sp    = dec ? 16'(m_sp - 16'd1) : 16'(m_sp + 16'd1);
        exp_val   = 16'h0;
        if (!dec) exp_val = stk[$];

        chk("ready_before_accept", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_rd = rd;
        sp_cur = m_sp; pc_cur = m_pc;
        mem_ack = 1'($urandom_range(0, 1));   // outside MEM: must be ignored
        @(negedge clk);
        // Scramble inputs after accept to prove the command was captured.
        cmd_valid = 1'b0;
        cmd_data = 16'($urandom); sp_cur = 16'($urandom); pc_cur = 16'($urandom);
        for (int w = 0; w <= waits; w++) begin
            chk("mem_req", mem_req, 1'b1);
            chk("mem_we", mem_we, dec);
            chk("mem_addr", mem_addr, exp_addr);
            if (dec) chk("mem_wdata", mem_wdata, exp_wdata);
            chk("ready_busy", cmd_ready, 1'b0);
            chk("done_busy", done | sp_wr | wr_en | pc_wr, 1'b0);
            if (w == waits) begin
                mem_ack = 1'b1;
                if (dec) phys[mem_addr] = mem_wdata;
                else mem_rdata = phys[mem_addr];
            end else begin
                mem_ack = 1'b0;
                mem_rdata = 16'($urandom);
            end
            @(negedge clk);
        end
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
        chk("upd_done", done, 1'b1);
        chk("upd_err", err, 1'b0);
        chk("upd_mem_req", mem_req, 1'b0);
        chk("upd_sp_wr", sp_wr, 1'b1);
        chk("upd_sp_in", sp_in, exp_sp);
        chk("upd_wr_en", wr_en, op == 2'd1);
        if (op == 2'd1) begin
            chk("upd_rd_addr", rd_addr, rd);
            chk("upd_rd_data", rd_data, exp_val);
        end
        chk("upd_pc_wr", pc_wr, (op == 2'd2) || (op == 2'd3));
        if (op == 2'd2) chk("upd_pc_in_call", pc_in, data);
        if (op == 2'd3) chk("upd_pc_in_ret", pc_in, exp_val);
        @(negedge clk);
        chk("ready_after", cmd_ready, 1'b1);
        chk("strobes_after", {done, err, sp_wr, wr_en, pc_wr, mem_req}, 6'b0);
        // Advance the model.
        m_sp = exp_sp;
        if (dec) stk.push_back(op == 2'd0 ? data : exp_wdata);
        else void'(stk.pop_back());
        if (op == 2'd2) m_pc = data;
        if (op == 2'd3) m_pc = exp_val;
    endtask

`ifdef STACK_GUARD_EN
    task automatic run_fault(input logic [1:0] op, input logic [15:0] sp);
        chk("fault_ready", cmd_ready, 1'b1);
        mem_ack = 1'b0;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = 16'h5555; cmd_rd = 4'h3;
        sp_cur = sp; pc_cur = m_pc;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("fault_done", done, 1'b1);
        chk("fault_err", err, 1'b1);
        chk("fault_no_writes", {mem_req, sp_wr, pc_wr, wr_en}, 4'b0);
        @(negedge clk);
        chk("fault_ready_after", cmd_ready, 1'b1);
        chk("fault_clear", {done, err, mem_req}, 3'b0);
    endtask
`endif

    initial begin
        // Reset state
        #2;
        chk("rst_ready", cmd_ready, 1'b0);
        chk("rst_strobes", {mem_req, sp_wr, pc_wr, wr_en, done, err}, 6'b0);
        chk("rst_data", {sp_in, pc_in, rd_data, mem_addr, mem_wdata}, 80'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed: push at empty stack, same-cycle ack
        m_sp = 16'hFFFF; m_pc = 16'h0100;
        run_cmd(2'd0, 16'h1234, 4'h0, 0);
        // POP rd=5 with two ack wait cycles
        run_cmd(2'd1, 16'h0000, 4'h5, 2);
        // CALL 0200 then RET
        run_cmd(2'd2, 16'h0200, 4'h0, 1);
        run_cmd(2'd3, 16'h0000, 4'h0, 0);
        chk("ret_pc_model", m_pc, 16'h0101);
        // Wrap: PUSH at SP=0000
        m_sp = 16'h0000; stk.delete();
        run_cmd(2'd0, 16'hABCD, 4'h0, 0);

`ifdef STACK_GUARD_EN
        run_fault(2'd1, 16'hFFFF);
        run_fault(2'd0, 16'hFF00);
`endif

        // Reset while in MEM before ack
        m_sp = 16'hFFFF;
        mem_ack = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 16'h7777; sp_cur = m_sp; pc_cur = m_pc;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("abort_mem_req_before", mem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("abort_mem_req_now", mem_req, 1'b0);
        chk("abort_ready_in_rst", cmd_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_no_wb0", {sp_wr, wr_en, pc_wr, done}, 4'b0);
        @(negedge clk);
        chk("abort_ready_after_rst", cmd_ready, 1'b1);
        chk("abort_no_wb1", {sp_wr, wr_en, pc_wr, done, mem_req}, 5'b0);

        // Randomized sequence against the model
        m_sp = 16'hFFFF; stk.delete();
        for (int n = 0; n < 40; n++) begin
            logic [1:0] op;
            int gap;
            if (stk.size() == 0 || (stk.size() < 6 && $urandom_range(0, 1) == 1))
                op = ($urandom_range(0, 1) == 1) ? 2'd2 : 2'd0;
            else
                op = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd1;
            run_cmd(op, 16'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                mem_ack = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("idle_quiet", {mem_req, done, sp_wr}, 3'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
